if_fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF_ID pipeline register. It owns the fetch PC and issues sequential word fetches to a variable-latency instruction memory. Returned words go into a small prefetch FIFO, and pc/instruction pairs are presented to IF_ID under a valid/ready handshake. It supports decode-stage stalls and redirects (branch/jump/jr) with queue flush and discard of the in-flight fetch.

---
 rtl/if_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 tb/tb_if_fetch_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch front end feeding the IF_ID pipeline register. Owns the
// fetch PC, issues one sequential word fetch at a time to a variable-latency
// instruction memory, buffers returned words in a DEPTH-entry prefetch FIFO
// and presents {pc, instruction} pairs to IF_ID with a valid/ready handshake.
// Redirects flush the FIFO and discard any fetch that is still in flight.
//
// Parameters:
//   DEPTH     prefetch FIFO entries (power of two, 2..16)
//   RESET_PC  fetch PC loaded on reset
//
// Ports:
//   clock           in   rising-edge clock
//   reset           in   synchronous active-low reset (0 = reset)
//   imem_req        out  fetch request, held high until imem_ack
//   imem_addr       out  word-aligned fetch address
//   imem_ack        in   response valid (ignored while imem_req=0)
//   imem_rdata      in   instruction word, valid with imem_ack
//   if_valid        out  head entry available to IF_ID
//   if_pc           out  PC of head entry
//   if_instruction  out  instruction of head entry
//   id_ready        in   IF_ID accepts the head this cycle
//   redirect_valid  in   control-flow change from ID/EXE
//   redirect_pc     in   new fetch target
//
// Optional feature (macro IF_FETCH_PERF_EN):
//   perf_fetch_cnt  out  accepted (non-discarded) pushes, saturating
//   perf_flush_cnt  out  redirect cycles, saturating
//   perf_stall_cnt  out  cycles with if_valid=1 and id_ready=0, saturating
// -----------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_req;
    logic [31:0]   r_addr;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];
    logic          r_if_valid;
    logic [31:0]   r_if_pc;
    logic [31:0]   r_if_instr;

    state_t        w_state_nx;
    logic          w_req_nx;
    logic [31:0]   w_addr_nx;
    logic [31:0]   w_fetch_pc_nx;
    logic          w_ack;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_count_after;
    logic          w_issue_ok;
    logic [31:0]   w_target;
    logic [31:0]   w_pc_inc;
    logic [AW-1:0] w_rd_ptr_nx;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_head_instr;

    // Handshake qualifiers, occupancy after this edge and the new head entry.
    always_comb begin
        w_ack         = imem_ack && r_req;
        w_pop         = r_if_valid && id_ready && !redirect_valid;
        w_push        = w_ack && (r_state == ST_REQ) && !redirect_valid;
        w_count_after = r_count + CW'(w_push) - CW'(w_pop);
        // A further request is only safe if its ack would still find a free slot.
        w_issue_ok    = (w_count_after < CW'(DEPTH));
        w_target      = redirect_pc & 32'hFFFF_FFFC;
        w_pc_inc      = r_fetch_pc + 32'd4;
        w_rd_ptr_nx   = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
        // When the FIFO drains to empty the word being pushed becomes the head.
        if (w_push && (r_wr_ptr == w_rd_ptr_nx)) begin
            w_head_pc    = r_addr;
            w_head_instr = imem_rdata;
        end else begin
            w_head_pc    = r_mem_pc[w_rd_ptr_nx];
            w_head_instr = r_mem_instr[w_rd_ptr_nx];
        end
    end

    // Fetch FSM next-state and next request/address/PC values.
    always_comb begin
        w_state_nx    = r_state;
        w_req_nx      = r_req;
        w_addr_nx     = r_addr;
        w_fetch_pc_nx = r_fetch_pc;
        if (redirect_valid) begin
            w_fetch_pc_nx = w_target;
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_IDLE;
                end
                ST_REQ, ST_DROP: begin
                    // A same-cycle ack retires the stale fetch; otherwise wait for it.
                    if (w_ack) begin
                        w_req_nx   = 1'b0;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_state_nx = ST_DROP;
                    end
                end
                default: begin
                    w_req_nx   = 1'b0;
                    w_state_nx = ST_IDLE;
                end
            endcase
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue_ok) begin
                        w_req_nx   = 1'b1;
                        w_addr_nx  = r_fetch_pc;
                        w_state_nx = ST_REQ;
                    end else begin
                        w_req_nx   = 1'b0;
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (w_ack) begin
                        w_fetch_pc_nx = w_pc_inc;
                        if (w_issue_ok) begin
                            w_addr_nx  = w_pc_inc;
                            w_state_nx = ST_REQ;
                        end else begin
                            w_req_nx   = 1'b0;
                            w_state_nx = ST_IDLE;
                        end
                    end else begin
                        w_state_nx = ST_REQ;
                    end
                end
                ST_DROP: begin
                    // FIFO is empty after the flush, so the target can issue at once.
                    if (w_ack) begin
                        w_req_nx   = 1'b1;
                        w_addr_nx  = r_fetch_pc;
                        w_state_nx = ST_REQ;
                    end else begin
                        w_state_nx = ST_DROP;
                    end
                end
                default: begin
                    w_req_nx   = 1'b0;
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, request and fetch PC registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nx;
            r_req      <= w_req_nx;
            r_addr     <= w_addr_nx;
            r_fetch_pc <= w_fetch_pc_nx;
        end
    end

    // Prefetch FIFO storage, pointers, occupancy and registered head outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'h0000_0000;
            r_if_instr <= 32'h0000_0000;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= 32'h0000_0000;
                r_mem_instr[i] <= 32'h0000_0000;
            end
        end else if (redirect_valid) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'h0000_0000;
            r_if_instr <= 32'h0000_0000;
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]    <= r_addr;
                r_mem_instr[r_wr_ptr] <= imem_rdata;
                r_wr_ptr              <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr   <= w_rd_ptr_nx;
            r_count    <= w_count_after;
            r_if_valid <= (w_count_after != '0);
            r_if_pc    <= w_head_pc;
            r_if_instr <= w_head_instr;
        end
    end

    assign imem_req       = r_req;
    assign imem_addr      = r_addr;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_if_pc;
    assign if_instruction = r_if_instr;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_stall;

    // Saturating performance counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_perf_fetch <= 32'h0000_0000;
            r_perf_flush <= 32'h0000_0000;
            r_perf_stall <= 32'h0000_0000;
        end else begin
            if (w_push && (r_perf_fetch != 32'hFFFF_FFFF)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (redirect_valid && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if (r_if_valid && !id_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_flush_cnt = r_perf_flush;
    assign perf_stall_cnt = r_perf_stall;
`else
    // Counters absent; fetch behaviour is unaffected.
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard: {pc, instruction} expected at the FIFO head, oldest first
    logic [63:0] q[$];

    // memory responder / reference model state
    logic        m_busy;
    logic        m_stale;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    int          m_wait;
    int          n_acks;
    int          n_pops;
    logic [31:0] last_pop_pc;

    // stimulus controls
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic        rdy    = 1'b1;
    logic        redir  = 1'b0;
    logic [31:0] redir_target = 32'h0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + {a[15:0], a[31:16]};
    endfunction

    task automatic do_reset(input int n);
        @(negedge clock);
        reset          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (n) @(posedge clock);
        @(negedge clock);
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        n_cmp++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RESET_PC); end
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc got=%h exp=0", if_pc); end
        n_cmp++; if (if_instruction !== 32'h0) begin n_bad++; $display("FAIL rst_instr got=%h exp=0", if_instruction); end
        reset   = 1'b1;
        q.delete();
        m_busy  = 1'b0;
        m_stale = 1'b0;
        m_pc    = RESET_PC;
        m_wait  = 0;
        n_acks  = 0;
    endtask

    // One clock: memory response, scoreboard checks, model update, drive inputs.
    task automatic cycle();
        logic ack_v;
        logic rd_v;
        logic rv_v;
        @(negedge clock);
        ack_v = 1'b0;
        rd_v  = rdy;
        rv_v  = redir;
        if (imem_req && !m_busy) begin
            m_busy = 1'b1;
            m_addr = imem_addr;
            m_wait = $urandom_range(lat_hi, lat_lo) - 1;
            if (!m_stale) begin
                n_cmp++;
                if (imem_addr !== m_pc) begin n_bad++; $display("FAIL fetch_addr got=%h exp=%h", imem_addr, m_pc); end
            end
        end else if (m_busy) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== m_addr) begin
                n_bad++; $display("FAIL req_hold got=%b/%h exp=1/%h", imem_req, imem_addr, m_addr);
            end
        end
        if (m_busy) begin
            if (m_wait == 0) ack_v = 1'b1;
            else m_wait--;
        end
        n_cmp++;
        if (if_valid !== (q.size() != 0)) begin
            n_bad++; $display("FAIL if_valid got=%b exp=%b", if_valid, (q.size() != 0));
        end
        if (q.size() != 0) begin
            n_cmp++;
            if (if_pc !== q[0][63:32] || if_instruction !== q[0][31:0]) begin
                n_bad++; $display("FAIL head got=%h/%h exp=%h/%h", if_pc, if_instruction, q[0][63:32], q[0][31:0]);
            end
        end
        if (q.size() != 0 && rd_v && !rv_v) begin
            last_pop_pc = q[0][63:32];
            void'(q.pop_front());
            n_pops++;
        end
        if (rv_v) begin
            q.delete();
            m_pc = redir_target & 32'hFFFF_FFFC;
            if (ack_v) m_stale = 1'b0;
            else if (m_busy) m_stale = 1'b1;
        end else if (ack_v) begin
            if (m_stale) begin
                m_stale = 1'b0;
            end else begin
                q.push_back({m_pc, word_of(m_pc)});
                n_cmp++;
                if (q.size() > DEPTH) begin n_bad++; $display("FAIL overflow got=%0d exp<=%0d", q.size(), DEPTH); end
                m_pc = m_pc + 32'd4;
            end
        end
        if (ack_v) begin
            m_busy = 1'b0;
            n_acks++;
        end
        imem_ack       = ack_v;
        imem_rdata     = ack_v ? word_of(m_addr) : 32'h0;
        id_ready       = rd_v;
        redirect_valid = rv_v;
        redirect_pc    = redir_target;
        redir          = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_addr(input logic [31:0] a, input string tag);
        int g;
        g = 0;
        while (!(imem_req && imem_addr == a) && g < 40) begin cycle(); g++; end
        n_cmp++;
        if (!(imem_req === 1'b1 && imem_addr === a)) begin
            n_bad++; $display("FAIL %s timeout got=%b/%h exp=1/%h", tag, imem_req, imem_addr, a);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
    endtask

    task automatic test_free_run();
        do_reset(2);
        lat_lo = 1; lat_hi = 1; rdy = 1'b1;
        n_pops = 0;
        cycle();
        n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid got=%b exp=1", if_valid); end
        repeat (16) cycle();
        n_cmp++; if (n_pops !== 16) begin n_bad++; $display("FAIL freerun_pops got=%0d exp=16", n_pops); end
        n_cmp++; if (last_pop_pc !== 32'h0000_303C) begin n_bad++; $display("FAIL freerun_last got=%h exp=0000303c", last_pop_pc); end
    endtask

    task automatic test_stall();
        do_reset(2);
        lat_lo = 1; lat_hi = 1; rdy = 1'b0;
        repeat (10) cycle();
        n_cmp++; if (n_acks !== DEPTH) begin n_bad++; $display("FAIL stall_acks got=%0d exp=%0d", n_acks, DEPTH); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req got=%b exp=0", imem_req); end
        rdy = 1'b1;
        n_pops = 0;
        cycle();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3010) begin
            n_bad++; $display("FAIL stall_resume got=%b/%h exp=1/00003010", imem_req, imem_addr);
        end
        repeat (3) cycle();
        n_cmp++; if (last_pop_pc !== 32'h0000_300C || n_pops !== 4) begin
            n_bad++; $display("FAIL stall_drain got=%h/%0d exp=0000300c/4", last_pop_pc, n_pops);
        end
    endtask

    task automatic test_redirect_drop();
        int g;
        do_reset(2);
        lat_lo = 3; lat_hi = 3; rdy = 1'b1;
        wait_addr(32'h0000_3008, "drop_wait");
        redir = 1'b1; redir_target = 32'h0000_4001;
        cycle();
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL drop_flush got=%b exp=0", if_valid); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3008) begin
            n_bad++; $display("FAIL drop_hold got=%b/%h exp=1/00003008", imem_req, imem_addr);
        end
        wait_addr(32'h0000_4000, "drop_next");
        n_pops = 0; g = 0;
        while (n_pops == 0 && g < 40) begin cycle(); g++; end
        n_cmp++; if (n_pops == 0 || last_pop_pc !== 32'h0000_4000) begin
            n_bad++; $display("FAIL drop_first got=%h exp=00004000", last_pop_pc);
        end
    endtask

    task automatic test_redirect_ack();
        do_reset(2);
        lat_lo = 1; lat_hi = 1; rdy = 1'b1;
        wait_addr(32'h0000_3004, "rack_wait");
        redir = 1'b1; redir_target = 32'h0000_5000;
        cycle();
        n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_bad++; $display("FAIL rack_empty got=%b/%b exp=0/0", if_valid, imem_req);
        end
        cycle();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_5000) begin
            n_bad++; $display("FAIL rack_next got=%b/%h exp=1/00005000", imem_req, imem_addr);
        end
        repeat (4) cycle();
    endtask

    task automatic test_wrap();
        lat_lo = 1; lat_hi = 2; rdy = 1'b1;
        redir = 1'b1; redir_target = 32'hFFFF_FFFE;
        cycle();
        wait_addr(32'hFFFF_FFFC, "wrap_top");
        wait_addr(32'h0000_0000, "wrap_zero");
        repeat (4) cycle();
    endtask

    task automatic test_random();
        lat_lo = 1; lat_hi = 5;
        for (int i = 0; i < 1500; i++) begin
            rdy = ($urandom_range(3, 0) != 0);
            if ($urandom_range(24, 0) == 0) begin
                redir = 1'b1;
                redir_target = $urandom;
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        int g;
        lat_lo = 4; lat_hi = 4; rdy = 1'b1;
        g = 0;
        while (!m_busy && g < 20) begin cycle(); g++; end
        do_reset(1);
        lat_lo = 1; lat_hi = 3;
        repeat (30) cycle();
    endtask

    initial begin
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        m_busy = 1'b0; m_stale = 1'b0; m_pc = RESET_PC; m_addr = 32'h0; m_wait = 0;
        n_acks = 0; n_pops = 0; last_pop_pc = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
